// File: rtl/uart_debug_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter between N_SRC byte sources.
// Define SRC_TAG_EN to send a tag byte (ID_BASE + source index) ahead of each granted packet.
module uart_debug_arbiter #(
    parameter int         N_SRC        = 3,
    parameter logic [7:0] ID_BASE      = 8'hF0,
    parameter int         BUSY_TIMEOUT = 4,
    parameter int         HOLD_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     req_valid,
    input  logic [8*N_SRC-1:0]   req_data,
    input  logic [N_SRC-1:0]     req_last,
    output logic [N_SRC-1:0]     req_ready,
    output logic [N_SRC-1:0]     grant,
    output logic [7:0]           uart_data,
    output logic                 uart_valid,
    input  logic                 uart_busy,
    output logic                 lock_abort
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [BW-1:0] BUSY_LAST = BW'((BUSY_TIMEOUT > 1) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 1) ? HOLD_TIMEOUT - 1 : 0);
    localparam bit            HOLD_EN   = (HOLD_TIMEOUT != 0);
`ifdef SRC_TAG_EN
    localparam bit            TAG_EN    = 1'b1;
`else
    localparam bit            TAG_EN    = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_HOLD       = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     owner_r, owner_s;
    logic [IW-1:0]     win_s;
    logic              last_r, last_s;
    logic [BW-1:0]     busy_cnt_r, busy_cnt_s;
    logic [HW-1:0]     hold_cnt_r, hold_cnt_s;
    logic [N_SRC-1:0]  grant_r, grant_s;
    logic [N_SRC-1:0]  ready_r, ready_s;
    logic [7:0]        data_r, data_s;
    logic              valid_r, valid_s;
    logic              abort_r, abort_s;

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] idx);
        logic [IW-1:0] r;
        if (idx == IW'(N_SRC - 1)) begin
            r = {IW{1'b0}};
        end else begin
            r = idx + IW'(1'b1);
        end
        return r;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_SRC-1:0] r;
        r = {N_SRC{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    // First requester found scanning start, start+1, ... modulo N_SRC.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] start,
                                              input logic [N_SRC-1:0] vld);
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        logic          found;
        idx   = start;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && vld[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                sel   = sel;
            end
            idx = inc_mod(idx);
        end
        return sel;
    endfunction

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        owner_s    = owner_r;
        last_s     = last_r;
        busy_cnt_s = busy_cnt_r;
        hold_cnt_s = hold_cnt_r;
        grant_s    = grant_r;
        data_s     = data_r;
        valid_s    = 1'b0;
        ready_s    = {N_SRC{1'b0}};
        abort_s    = 1'b0;
        win_s      = rr_pick(ptr_r, req_valid);
        case (state_r)
            S_IDLE: begin
                if ((|req_valid) && !uart_busy) begin
                    owner_s    = win_s;
                    grant_s    = onehot(win_s);
                    valid_s    = 1'b1;
                    busy_cnt_s = {BW{1'b0}};
                    state_s    = S_WAIT_START;
                    if (TAG_EN) begin
                        data_s = ID_BASE + 8'(win_s);
                        last_s = 1'b0;
                    end else begin
                        data_s  = req_data[8*int'(win_s) +: 8];
                        ready_s = onehot(win_s);
                        last_s  = req_last[win_s];
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (req_valid[owner_r] && !uart_busy) begin
                    data_s     = req_data[8*int'(owner_r) +: 8];
                    valid_s    = 1'b1;
                    ready_s    = onehot(owner_r);
                    last_s     = req_last[owner_r];
                    busy_cnt_s = {BW{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                    state_s    = S_WAIT_START;
                end else if (HOLD_EN && (hold_cnt_r == HOLD_LAST)) begin
                    abort_s    = 1'b1;
                    grant_s    = {N_SRC{1'b0}};
                    ptr_s      = inc_mod(owner_r);
                    hold_cnt_s = {HW{1'b0}};
                    state_s    = S_IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1'b1);
                end
            end
            S_WAIT_START: begin
                // A transmitter that never raises busy is treated as having sent the byte.
                if (uart_busy || (busy_cnt_r == BUSY_LAST)) begin
                    state_s = S_WAIT_DONE;
                end else begin
                    busy_cnt_s = busy_cnt_r + BW'(1'b1);
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (last_r) begin
                        grant_s = {N_SRC{1'b0}};
                        ptr_s   = inc_mod(owner_r);
                        state_s = S_IDLE;
                    end else begin
                        hold_cnt_s = {HW{1'b0}};
                        state_s    = S_HOLD;
                    end
                end else begin
                    state_s = S_WAIT_DONE;
                end
            end
            default: begin
                grant_s = {N_SRC{1'b0}};
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight byte and lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            ptr_r      <= {IW{1'b0}};
            owner_r    <= {IW{1'b0}};
            last_r     <= 1'b0;
            busy_cnt_r <= {BW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            grant_r    <= {N_SRC{1'b0}};
            ready_r    <= {N_SRC{1'b0}};
            data_r     <= 8'h00;
            valid_r    <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            owner_r    <= owner_s;
            last_r     <= last_s;
            busy_cnt_r <= busy_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            grant_r    <= grant_s;
            ready_r    <= ready_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            abort_r    <= abort_s;
        end
    end

    assign req_ready  = ready_r;
    assign grant      = grant_r;
    assign uart_data  = data_r;
    assign uart_valid = valid_r;
    assign lock_abort = abort_r;

endmodule

// File: tb/tb_uart_debug_arbiter.sv
// Scoreboard bench for uart_debug_arbiter: per-source byte queues, a round-robin
// arbitration model and a behavioural transmitter (busy 1 cycle after valid, 10 cycles).
`timescale 1ns/1ps
module tb_uart_debug_arbiter;
    localparam int         N        = 3;
    localparam logic [7:0] IDB      = 8'hF0;
    localparam int         BT       = 4;
    localparam int         HT       = 16;
    localparam int         BUSY_LEN = 10;
`ifdef SRC_TAG_EN
    localparam int         TAG      = 1;
`else
    localparam int         TAG      = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]     uart_data;
    logic           uart_valid, uart_busy, lock_abort;

    uart_debug_arbiter #(.N_SRC(N), .ID_BASE(IDB), .BUSY_TIMEOUT(BT), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .uart_data(uart_data),
        .uart_valid(uart_valid), .uart_busy(uart_busy), .lock_abort(lock_abort));

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    beat_t src_q [N][$];
    beat_t exp_q [N][$];
    int    budget [N];
    int    ready_cnt [N];
    int    total = 0, bad = 0;
    int    cyc = 0, busy_cnt, fall_cyc;
    bit    busy_en = 1'b1;
    logic [N-1:0] prev_req;
    int    ptr_m = 0, owner_m = -1, lock_m = -1;
    bit    tag_pend = 1'b0;
    int    grant_log[$];
    logic [7:0] byte_log[$];
    int    vcyc_q[$];
    int    abort_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d want none", name, act);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = {N{1'b0}};
        if (i >= 0 && i < N) r[i] = 1'b1;
        return r;
    endfunction

    // Reference arbitration: first requester from ptr, wrapping around.
    function automatic int rr_model(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N] === 1'b1) return (p + k) % N;
        return -1;
    endfunction

    function automatic int log_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return -1;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += src_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    // Transmitter model: busy rises the cycle after a valid pulse and lasts BUSY_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
            fall_cyc <= 0;
        end else if (uart_valid && busy_en) begin
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) fall_cyc <= cyc + 1;
        end
    end
    assign uart_busy = (busy_cnt != 0);

    // Cycle count and the request vector the DUT sampled on this edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_req <= req_valid;
    end

    // Source drivers: hold the head byte until its accept pulse, then present the next.
    initial begin
        req_valid = {N{1'b0}};
        req_last  = {N{1'b0}};
        req_data  = {(8*N){1'b0}};
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] === 1'b1 && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    if (budget[i] > 0) budget[i]--;
                end
                if (src_q[i].size() > 0 && budget[i] != 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = src_q[i][0].data;
                    req_last[i]         = src_q[i][0].last;
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'($urandom);
                    req_last[i]         = 1'($urandom);
                end
            end
        end
    end

    // Monitor: arbitration, lock, tag, data and accept-pulse checks.
    initial begin : monitor
        logic [N-1:0] prev_g;
        beat_t b;
        int w;
        prev_g = {N{1'b0}};
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (grant != {N{1'b0}} && prev_g == {N{1'b0}}) begin
                    w = rr_model(ptr_m, prev_req);
                    chk("arb_winner", grant, oh(w));
                    owner_m  = w;
                    tag_pend = (TAG != 0);
                    grant_log.push_back(w);
                end
                if (uart_valid) begin
                    byte_log.push_back(uart_data);
                    vcyc_q.push_back(cyc);
                    chk("valid_while_busy", uart_busy, 0);
                    if (lock_m >= 0) chk("lock_owner", owner_m, lock_m);
                    chk("grant_owner", grant, oh(owner_m));
                    if (owner_m < 0) begin
                        fail_now("byte_without_owner", owner_m);
                    end else if (tag_pend) begin
                        chk("tag_byte", uart_data, IDB + 8'(owner_m));
                        chk("tag_no_ready", req_ready, 0);
                        tag_pend = 1'b0;
                        lock_m   = owner_m;
                    end else if (exp_q[owner_m].size() == 0) begin
                        fail_now("unexpected_byte", uart_data);
                    end else begin
                        b = exp_q[owner_m].pop_front();
                        chk("data", uart_data, b.data);
                        chk("ready_pulse", req_ready, oh(owner_m));
                        ready_cnt[owner_m]++;
                        if (b.last) begin
                            lock_m = -1;
                            ptr_m  = (owner_m + 1) % N;
                        end else begin
                            lock_m = owner_m;
                        end
                    end
                end else if (req_ready != {N{1'b0}}) begin
                    fail_now("ready_without_valid", req_ready);
                end
                if (lock_abort) begin
                    abort_cyc.push_back(cyc);
                    chk("abort_grant", grant, 0);
                    lock_m = -1;
                    ptr_m  = (owner_m + 1) % N;
                end
                prev_g = grant;
            end else begin
                prev_g = {N{1'b0}};
            end
        end
    end

    task automatic push_byte(input int s, input logic [7:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        src_q[s].push_back(b);
        exp_q[s].push_back(b);
    endtask

    task automatic push_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) push_byte(s, 8'($urandom), (k == len - 1));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({name, "_grant"}, grant, 0);
        chk({name, "_ready"}, req_ready, 0);
        chk({name, "_valid"}, uart_valid, 0);
        chk({name, "_data"}, uart_data, 0);
        chk({name, "_abort"}, lock_abort, 0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            budget[i]    = -1;
            ready_cnt[i] = 0;
        end
        ptr_m = 0; owner_m = -1; lock_m = -1; tag_pend = 1'b0;
        grant_log.delete(); byte_log.delete(); vcyc_q.delete(); abort_cyc.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (!(pending() == 0 && grant == {N{1'b0}} && !uart_busy && !uart_valid) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, (n >= 4000), 0);
    endtask

    task automatic wait_ready(input string name, input int s, input int cnt);
        int n = 0;
        while (ready_cnt[s] < cnt && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, (n >= 500), 0);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            budget[i]    = -1;
            ready_cnt[i] = 0;
        end
        do_reset("reset");

        // Single three-byte packet from source 0.
        @(posedge clk); #1;
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
        drain("t1");
        chk("t1_ready_cnt", ready_cnt[0], 3);
        chk("t1_bytes", byte_log.size(), 3 + TAG);
        chk("t1_last_byte", byte_log[byte_log.size() - 1], 8'h33);
        chk("t1_grant_end", grant, 0);

        // Contention after reset, then contention with the pointer moved past source 0.
        do_reset("t2_reset");
        @(posedge clk); #1;
        push_pkt(0, 2); push_pkt(2, 2);
        drain("t2a");
        chk("t2_first", log_at(0), 0);
        chk("t2_second", log_at(1), 2);
        grant_log.delete();
        @(posedge clk); #1;
        push_pkt(0, 1);
        drain("t2b");
        @(posedge clk); #1;
        push_pkt(0, 2); push_pkt(2, 2);
        drain("t2c");
        chk("t2_rr_first", log_at(1), 2);
        chk("t2_rr_second", log_at(2), 0);

        // A second source requesting mid-packet waits for the owner's last byte.
        grant_log.delete();
        @(posedge clk); #1;
        push_pkt(0, 4);
        wait_ready("t3_wait", 0, ready_cnt[0] + 1);
        push_pkt(1, 2);
        drain("t3");
        chk("t3_owner_first", log_at(0), 0);
        chk("t3_owner_second", log_at(1), 1);

        // Transmitter that never raises busy: bytes paced by the start timeout.
        busy_en = 1'b0;
        vcyc_q.delete();
        @(posedge clk); #1;
        push_pkt(1, 3);
        drain("t4");
        busy_en = 1'b1;
        chk("t4_count", vcyc_q.size(), 3 + TAG);
        for (int k = 1; k < vcyc_q.size(); k++)
            chk_rng("t4_gap", vcyc_q[k] - vcyc_q[k-1], BT + 1, BT + 3);

        // Owner stalls mid-packet: lock released after HT idle cycles, waiting source served.
        grant_log.delete();
        abort_cyc.delete();
        budget[0] = 1;
        @(posedge clk); #1;
        push_pkt(0, 3);
        wait_ready("t5_first", 0, ready_cnt[0] + 1);
        push_pkt(1, 2);
        n = 0;
        while (abort_cyc.size() == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_abort_seen", (abort_cyc.size() > 0), 1);
        if (abort_cyc.size() > 0) chk_rng("t5_abort_delay", abort_cyc[0] - fall_cyc, HT, HT + 2);
        wait_ready("t5_src1", 1, ready_cnt[1] + 2);
        chk("t5_next_owner", log_at(1), 1);
        budget[0] = -1;
        drain("t5");
        chk("t5_abort_once", abort_cyc.size(), 1);

        // Reset in the middle of a packet; nothing resumes afterwards.
        @(posedge clk); #1;
        push_pkt(2, 4);
        wait_ready("t5r_wait", 2, 1);
        do_reset("t5_midreset");
        repeat (40) @(posedge clk);
        #1;
        chk("t5_no_resume", byte_log.size(), 0);

        // Single-byte packet, with a leading tag byte when tagging is built in.
        @(posedge clk); #1;
        push_byte(2, 8'hAA, 1'b1);
        drain("t6");
        chk("t6_ready_cnt", ready_cnt[2], 1);
        chk("t6_bytes", byte_log.size(), 1 + TAG);
        if (byte_log.size() == 1 + TAG) begin
            if (TAG != 0) chk("t6_tag", byte_log[0], IDB + 8'd2);
            chk("t6_data", byte_log[TAG], 8'hAA);
        end

        // Randomized packets from random sources at random times.
        for (int it = 0; it < 30; it++) begin
            @(posedge clk); #1;
            push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
            repeat ($urandom_range(0, 25)) @(posedge clk);
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
